dsp_frame_sequencer: RTL and testbench

//  Per-sample-period controller for the DSP core. On each audio sample tick it snapshots the
//  NUM_CH input samples into the core input bank, pulses the core start strobe, and supervises

---
 rtl/dsp_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dsp_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_frame_sequencer
//
// Per-sample-period controller for the DSP core.  On every accepted audio
// sample tick it latches the live input samples into the core input bank,
// strobes the core start, and watches the program until the core reports
// done.  The core results are then captured into a stable output bank.
// Dropped ticks (overruns) and watchdog aborts (hangs) are counted.
//
// Optional build macro:
//   DSP_CYCLE_STATS_EN  when defined, peak_cycles tracks the largest
//                       start-to-done cycle count (strobe cycle through done
//                       cycle, inclusive); when undefined peak_cycles is 0.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   enable        1 = accept sample ticks; 0 = finish current frame then idle
//   sample_tick   one-cycle pulse per audio sample period
//   in_samples    NUM_CH live samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   core_inputs   latched bank presented to the core (same packing)
//   core_start    one-cycle start strobe to the core
//   core_done     one-cycle pulse from the core: program finished
//   core_outputs  core results, valid in the core_done cycle
//   out_samples   captured results, held until the next capture
//   out_valid     one-cycle pulse: out_samples updated this cycle
//   busy          1 while a frame is running
//   clear_err     synchronous clear of overrun_cnt, timeout_cnt, peak_cycles
//   overrun_cnt   ticks dropped while a frame was running (saturating)
//   timeout_cnt   frames aborted by the watchdog (saturating)
//   peak_cycles   largest start-to-done cycle count observed
// ---------------------------------------------------------------------------
module dsp_frame_sequencer #(
   parameter int NUM_CH     = 8,
   parameter int SAMPLE_W   = 36,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         sample_tick,
   input  logic [NUM_CH*SAMPLE_W-1:0]   in_samples,
   output logic [NUM_CH*SAMPLE_W-1:0]   core_inputs,
   output logic                         core_start,
   input  logic                         core_done,
   input  logic [NUM_CH*SAMPLE_W-1:0]   core_outputs,
   output logic [NUM_CH*SAMPLE_W-1:0]   out_samples,
   output logic                         out_valid,
   output logic                         busy,
   input  logic                         clear_err,
   output logic [CNT_W-1:0]             overrun_cnt,
   output logic [CNT_W-1:0]             timeout_cnt,
   output logic [CNT_W-1:0]             peak_cycles
);

   localparam int RUN_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [RUN_W-1:0]   run_cnt_r;
   logic               done_s;
   logic               start_s;
   logic               capture_s;
   logic               overrun_s;
   logic               timeout_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == CNT_MAX) begin
         return CNT_MAX;
      end else begin
         return value + CNT_W'(1);
      end
   endfunction

   // Next-state and per-cycle event decode.
   always_comb begin
      next_state_s = state_r;
      start_s      = 1'b0;
      capture_s    = 1'b0;
      overrun_s    = 1'b0;
      timeout_s    = 1'b0;
      // core_start is high exactly in the strobe cycle; a done seen then is ignored
      done_s       = core_done & ~core_start;
      case (state_r)
         ST_IDLE: begin
            if (sample_tick && enable) begin
               start_s      = 1'b1;
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (done_s) begin
               capture_s = 1'b1;
               // a tick coinciding with done chains straight into the next frame
               if (sample_tick && enable) begin
                  start_s      = 1'b1;
                  next_state_s = ST_RUN;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               overrun_s = sample_tick;
               if (run_cnt_r == RUN_LAST) begin
                  timeout_s    = 1'b1;
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register, control strobes and run-cycle counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         core_start <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         run_cnt_r  <= {RUN_W{1'b0}};
      end else begin
         state_r    <= next_state_s;
         core_start <= start_s;
         out_valid  <= capture_s;
         busy       <= (next_state_s == ST_RUN);
         if (start_s) begin
            run_cnt_r <= {RUN_W{1'b0}};
         end else if (state_r == ST_RUN) begin
            run_cnt_r <= run_cnt_r + RUN_W'(1);
         end else begin
            run_cnt_r <= run_cnt_r;
         end
      end
   end

   // Core input bank and captured output bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_inputs <= {(NUM_CH*SAMPLE_W){1'b0}};
         out_samples <= {(NUM_CH*SAMPLE_W){1'b0}};
      end else begin
         if (start_s) begin
            core_inputs <= in_samples;
         end
         if (capture_s) begin
            out_samples <= core_outputs;
         end
      end
   end

   // Error counters; clear_err wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun_cnt <= {CNT_W{1'b0}};
         timeout_cnt <= {CNT_W{1'b0}};
      end else if (clear_err) begin
         overrun_cnt <= {CNT_W{1'b0}};
         timeout_cnt <= {CNT_W{1'b0}};
      end else begin
         if (overrun_s) begin
            overrun_cnt <= sat_inc(overrun_cnt);
         end
         if (timeout_s) begin
            timeout_cnt <= sat_inc(timeout_cnt);
         end
      end
   end

`ifdef DSP_CYCLE_STATS_EN
   logic [CNT_W-1:0] frame_cycles_s;

   // run_cnt is 0 in the strobe cycle, so +1 counts strobe through done inclusive.
   assign frame_cycles_s = CNT_W'(run_cnt_r) + CNT_W'(1);

   // Peak start-to-done tracker, updated on each capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         peak_cycles <= {CNT_W{1'b0}};
      end else if (clear_err) begin
         peak_cycles <= {CNT_W{1'b0}};
      end else if (capture_s && (frame_cycles_s > peak_cycles)) begin
         peak_cycles <= frame_cycles_s;
      end
   end
`else
   assign peak_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Self-checking bench for dsp_frame_sequencer.  A frame-level model (running
// flag, cycles since strobe, banks, counters) is stepped once per clock.
module tb_dsp_frame_sequencer;
   localparam int NUM_CH     = 8;
   localparam int SAMPLE_W   = 36;
   localparam int MAX_CYCLES = 1024;
   localparam int CNT_W      = 16;
   localparam int BW         = NUM_CH * SAMPLE_W;
   localparam int CMAX       = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0, enable = 1'b0, sample_tick = 1'b0, core_done = 1'b0, clear_err = 1'b0;
   logic [BW-1:0] in_samples = '0, core_outputs = '0;
   logic [BW-1:0] core_inputs, out_samples;
   logic core_start, out_valid, busy;
   logic [CNT_W-1:0] overrun_cnt, timeout_cnt, peak_cycles;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dsp_frame_sequencer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
      .in_samples(in_samples), .core_inputs(core_inputs), .core_start(core_start),
      .core_done(core_done), .core_outputs(core_outputs), .out_samples(out_samples),
      .out_valid(out_valid), .busy(busy), .clear_err(clear_err),
      .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt), .peak_cycles(peak_cycles));

   // ---------------- reference model ----------------
   logic [SAMPLE_W-1:0] m_in [NUM_CH];
   logic [SAMPLE_W-1:0] m_out [NUM_CH];
   bit m_run, m_start, m_valid;
   int m_age, m_ovr, m_tmo, m_peak;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin m_in[i] = '0; m_out[i] = '0; end
      m_run = 0; m_start = 0; m_valid = 0; m_age = 0; m_ovr = 0; m_tmo = 0; m_peak = 0;
   endtask

   task automatic model_latch();
      for (int i = 0; i < NUM_CH; i++) m_in[i] = in_samples[i*SAMPLE_W +: SAMPLE_W];
   endtask

   // Applies the frame rules to the inputs the DUT will sample at the next edge.
   task automatic model_step();
      bit nstart, nvalid, dn;
      if (!reset) begin
         model_reset();
      end else begin
         nstart = 0; nvalid = 0;
         dn = core_done && m_run && !m_start;
         if (!m_run) begin
            if (sample_tick && enable) begin
               model_latch(); nstart = 1; m_run = 1; m_age = 0;
            end
         end else if (dn) begin
            for (int i = 0; i < NUM_CH; i++) m_out[i] = core_outputs[i*SAMPLE_W +: SAMPLE_W];
            nvalid = 1;
            if (m_age + 1 > m_peak) m_peak = m_age + 1;
            if (sample_tick && enable) begin
               model_latch(); nstart = 1; m_age = 0;
            end else begin
               m_run = 0;
            end
         end else begin
            if (sample_tick) m_ovr = (m_ovr == CMAX) ? CMAX : m_ovr + 1;
            if (m_age == MAX_CYCLES - 1) begin
               m_tmo = (m_tmo == CMAX) ? CMAX : m_tmo + 1;
               m_run = 0;
            end else begin
               m_age++;
            end
         end
         if (clear_err) begin m_ovr = 0; m_tmo = 0; m_peak = 0; end
         m_start = nstart; m_valid = nvalid;
      end
   endtask

   function automatic int exp_peak();
`ifdef DSP_CYCLE_STATS_EN
      return m_peak;
`else
      return 0;
`endif
   endfunction

   // Advance one clock: called just after a falling edge, returns at the next one.
   task automatic cyc();
      model_step();
      @(negedge clk);
   endtask

   task automatic randomize_bank(output logic [BW-1:0] bank);
      for (int i = 0; i < NUM_CH; i++) bank[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'({$urandom(), $urandom()});
   endtask

   task automatic start_frame();
      enable = 1'b1; sample_tick = 1'b1; randomize_bank(in_samples);
      cyc();
      sample_tick = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++; if (core_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl: got start=%b busy=%b valid=%b expected 0", core_start, busy, out_valid); end
      checks++; if (overrun_cnt !== '0 || timeout_cnt !== '0 || peak_cycles !== '0) begin
         failures++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0", overrun_cnt, timeout_cnt, peak_cycles); end
      checks++; if (core_inputs !== '0 || out_samples !== '0) begin
         failures++; $display("FAIL reset_banks: got %h / %h expected 0", core_inputs, out_samples); end
   endtask

   task automatic test_start();
      logic [SAMPLE_W-1:0] e;
      enable = 1'b1; sample_tick = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin e = SAMPLE_W'((i + 1) << 10); in_samples[i*SAMPLE_W +: SAMPLE_W] = e; end
      cyc();
      sample_tick = 1'b0; in_samples = '0;
      checks++; if (core_start !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL start_strobe: got start=%b busy=%b expected 1/1", core_start, busy); end
      for (int i = 0; i < NUM_CH; i++) begin
         e = SAMPLE_W'((i + 1) << 10);
         checks++; if (core_inputs[i*SAMPLE_W +: SAMPLE_W] !== e) begin
            failures++; $display("FAIL start_bank ch%0d: got %h expected %h", i, core_inputs[i*SAMPLE_W +: SAMPLE_W], e); end
      end
      cyc();
      checks++; if (core_start !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL start_single: got start=%b busy=%b expected 0/1", core_start, busy); end
   endtask

   // Frame entered at cycle 1 after the strobe; done lands in cycle 19 -> 20 cycles inclusive.
   task automatic test_capture();
      logic [SAMPLE_W-1:0] e;
      int exp_pk;
      repeat (18) cyc();
      core_done = 1'b1;
      for (int i = 0; i < NUM_CH; i++) core_outputs[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(i);
      cyc();
      core_done = 1'b0;
`ifdef DSP_CYCLE_STATS_EN
      exp_pk = 20;
`else
      exp_pk = 0;
`endif
      checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL capture_valid: got valid=%b busy=%b expected 1/0", out_valid, busy); end
      for (int i = 0; i < NUM_CH; i++) begin
         e = SAMPLE_W'(i);
         checks++; if (out_samples[i*SAMPLE_W +: SAMPLE_W] !== e) begin
            failures++; $display("FAIL capture_bank ch%0d: got %h expected %h", i, out_samples[i*SAMPLE_W +: SAMPLE_W], e); end
      end
      checks++; if (peak_cycles !== CNT_W'(exp_pk)) begin
         failures++; $display("FAIL capture_peak: got %0d expected %0d", peak_cycles, exp_pk); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin
         failures++; $display("FAIL capture_pulse: got valid=%b expected 0", out_valid); end
   endtask

   task automatic test_overrun();
      int starts = 0;
      start_frame();
      repeat (4) cyc();
      sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
      checks++; if (overrun_cnt !== CNT_W'(1)) begin
         failures++; $display("FAIL overrun_count: got %0d expected 1", overrun_cnt); end
      for (int k = 0; k < 4; k++) begin if (core_start) starts++; cyc(); end
      checks++; if (starts != 0 || busy !== 1'b1) begin
         failures++; $display("FAIL overrun_nostart: got starts=%0d busy=%b expected 0/1", starts, busy); end
      clear_err = 1'b1; cyc(); clear_err = 1'b0;
      checks++; if (overrun_cnt !== '0) begin
         failures++; $display("FAIL overrun_clear: got %0d expected 0", overrun_cnt); end
      core_done = 1'b1; cyc(); core_done = 1'b0; cyc();
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] nin, nout;
      start_frame();
      repeat (3) cyc();
      randomize_bank(nin); randomize_bank(nout);
      in_samples = nin; core_outputs = nout; core_done = 1'b1; sample_tick = 1'b1;
      cyc();
      core_done = 1'b0; sample_tick = 1'b0;
      checks++; if (out_valid !== 1'b1 || core_start !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL b2b_strobes: got valid=%b start=%b busy=%b expected 1/1/1", out_valid, core_start, busy); end
      checks++; if (core_inputs !== nin || out_samples !== nout) begin
         failures++; $display("FAIL b2b_banks: got %h / %h expected %h / %h", core_inputs, out_samples, nin, nout); end
      checks++; if (overrun_cnt !== '0) begin
         failures++; $display("FAIL b2b_overrun: got %0d expected 0", overrun_cnt); end
      cyc();
      checks++; if (core_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL b2b_next: got start=%b valid=%b busy=%b expected 0/0/1", core_start, out_valid, busy); end
      core_done = 1'b1; cyc(); core_done = 1'b0; cyc();
   endtask

   task automatic test_watchdog();
      int n = 0, nval = 0;
      start_frame();
      while (busy && n < MAX_CYCLES + 16) begin
         if (out_valid) nval++;
         cyc(); n++;
      end
      checks++; if (n != MAX_CYCLES) begin
         failures++; $display("FAIL wdog_cycles: got %0d expected %0d", n, MAX_CYCLES); end
      checks++; if (timeout_cnt !== CNT_W'(1) || nval != 0) begin
         failures++; $display("FAIL wdog_count: got tmo=%0d valids=%0d expected 1/0", timeout_cnt, nval); end
      core_done = 1'b1; randomize_bank(core_outputs); cyc(); core_done = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL wdog_late_done: got valid=%b busy=%b expected 0/0", out_valid, busy); end
      for (int i = 0; i < NUM_CH; i++) begin
         checks++; if (out_samples[i*SAMPLE_W +: SAMPLE_W] !== m_out[i]) begin
            failures++; $display("FAIL wdog_hold ch%0d: got %h expected %h", i, out_samples[i*SAMPLE_W +: SAMPLE_W], m_out[i]); end
      end
   endtask

   task automatic test_enable_drop();
      start_frame();
      cyc(); enable = 1'b0; repeat (3) cyc();
      core_done = 1'b1; sample_tick = 1'b1; cyc(); core_done = 1'b0; sample_tick = 1'b0;
      checks++; if (out_valid !== 1'b1 || core_start !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL endrop: got valid=%b start=%b busy=%b expected 1/0/0", out_valid, core_start, busy); end
      checks++; if (overrun_cnt !== CNT_W'(m_ovr)) begin
         failures++; $display("FAIL endrop_overrun: got %0d expected %0d", overrun_cnt, m_ovr); end
   endtask

   task automatic test_idle_disabled();
      enable = 1'b0; sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
      checks++; if (core_start !== 1'b0 || busy !== 1'b0 || overrun_cnt !== CNT_W'(m_ovr)) begin
         failures++; $display("FAIL idle_disabled: got start=%b busy=%b ovr=%0d expected 0/0/%0d", core_start, busy, overrun_cnt, m_ovr); end
      cyc(); enable = 1'b1;
   endtask

   task automatic test_done_in_strobe();
      start_frame();
      core_done = 1'b1; cyc(); core_done = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL strobe_done: got valid=%b busy=%b expected 0/1", out_valid, busy); end
      core_done = 1'b1; cyc(); core_done = 1'b0;
      checks++; if (out_valid !== 1'b1) begin
         failures++; $display("FAIL strobe_done_later: got valid=%b expected 1", out_valid); end
      cyc();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         enable = ($urandom_range(0, 15) != 0);
         sample_tick = ($urandom_range(0, 7) == 0);
         core_done = ($urandom_range(0, 5) == 0);
         clear_err = ($urandom_range(0, 60) == 0);
         randomize_bank(in_samples); randomize_bank(core_outputs);
         cyc();
         checks++; if (core_start !== m_start || busy !== m_run || out_valid !== m_valid) begin
            failures++; $display("FAIL rnd_ctrl k=%0d: got %b%b%b expected %b%b%b", k, core_start, busy, out_valid, m_start, m_run, m_valid); end
         checks++; if (overrun_cnt !== CNT_W'(m_ovr) || timeout_cnt !== CNT_W'(m_tmo) || peak_cycles !== CNT_W'(exp_peak())) begin
            failures++; $display("FAIL rnd_cnt k=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", k, overrun_cnt, timeout_cnt, peak_cycles, m_ovr, m_tmo, exp_peak()); end
         for (int i = 0; i < NUM_CH; i++) begin
            checks++; if (core_inputs[i*SAMPLE_W +: SAMPLE_W] !== m_in[i] || out_samples[i*SAMPLE_W +: SAMPLE_W] !== m_out[i]) begin
               failures++; $display("FAIL rnd_bank k=%0d ch%0d: got %h/%h expected %h/%h", k, i,
                  core_inputs[i*SAMPLE_W +: SAMPLE_W], out_samples[i*SAMPLE_W +: SAMPLE_W], m_in[i], m_out[i]); end
         end
      end
      sample_tick = 1'b0; core_done = 1'b0; clear_err = 1'b0; enable = 1'b1;
   endtask

   task automatic test_async_reset();
      clear_err = 1'b1; cyc(); clear_err = 1'b0;
      start_frame(); sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
      core_done = 1'b1; cyc(); core_done = 1'b0;
      start_frame();
      checks++; if (core_start !== 1'b1 || overrun_cnt !== CNT_W'(1)) begin
         failures++; $display("FAIL areset_setup: got start=%b ovr=%0d expected 1/1", core_start, overrun_cnt); end
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++; if (core_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL areset_ctrl: got start=%b busy=%b valid=%b expected 0", core_start, busy, out_valid); end
      checks++; if (overrun_cnt !== '0 || timeout_cnt !== '0 || peak_cycles !== '0 || core_inputs !== '0 || out_samples !== '0) begin
         failures++; $display("FAIL areset_state: got %0d/%0d/%0d expected 0", overrun_cnt, timeout_cnt, peak_cycles); end
      @(negedge clk); reset = 1'b1; cyc();
      checks++; if (busy !== 1'b0 || core_start !== 1'b0) begin
         failures++; $display("FAIL areset_release: got busy=%b start=%b expected 0/0", busy, core_start); end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b1;
      test_start();
      test_capture();
      test_overrun();
      test_back_to_back();
      test_watchdog();
      test_enable_drop();
      test_idle_disabled();
      test_done_in_strobe();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
